// File: rtl/ifu_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_fetch_pkg;

  localparam int unsigned XLEN = 64;
  localparam int unsigned ILEN = 32;
  localparam logic [XLEN-1:0] RESET_PC = 64'h8000_0000;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] inst;
  } buf_entry_t;

endpackage

// File: rtl/ifu_inst_buf.sv
// Synchronous FIFO holding fetched {pc, inst} entries; DEPTH must be a power of two.
module ifu_inst_buf #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 96,
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [CW-1:0]    count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + AW'(1);
      if (pop)  rptr_q <= rptr_q + AW'(1);
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: reads are qualified by count.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wptr_q] <= wdata;
  end

  assign rdata = mem_q[rptr_q];
  assign count = count_q;
  assign empty = (count_q == '0);

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: PC, one-outstanding imem requests, buffered delivery to decode.
// Optional misaligned-redirect trap enabled by defining IFU_ALIGN_CHECK_EN.
module ifu_fetch #(
  parameter int unsigned     XLEN      = ifu_fetch_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC  = ifu_fetch_pkg::RESET_PC,
  parameter int unsigned     BUF_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [31:0]     imem_resp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] inst_pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            fetch_fault
);

  import ifu_fetch_pkg::*;

  localparam int unsigned CW = $clog2(BUF_DEPTH + 1);
  localparam int unsigned OW = CW + 1;

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic            drop_q, drop_d;
  logic            fault_q, fault_set, fault_next;

  logic            req_fire, resp_fire;
  logic            push, pop, credit;
  logic [OW-1:0]   occ_next;
  logic [CW-1:0]   buf_count;
  logic            buf_empty;
  buf_entry_t      push_entry, head_entry;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      pc_q     <= RESET_PC;
      req_pc_q <= '0;
      drop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
      drop_q   <= drop_d;
    end
  end

`ifdef IFU_ALIGN_CHECK_EN
  assign fault_set = redirect_valid && (redirect_pc[1:0] != 2'b00);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fault_q <= 1'b0;
    else        fault_q <= fault_q | fault_set;
  end
`else
  assign fault_set = 1'b0;
  assign fault_q   = 1'b0;
`endif

  assign fault_next = fault_q | fault_set;

  // A redirect cancels this cycle's push and pop; the buffer is flushed instead.
  always_comb begin
    req_fire  = (state_q == StReq) && imem_req_ready;
    resp_fire = (state_q == StWait) && imem_resp_valid;
    push      = !redirect_valid && resp_fire && !drop_q;
    pop       = !redirect_valid && !buf_empty && inst_ready;
    occ_next  = OW'(buf_count) + OW'(push) - OW'(pop);
    credit    = (occ_next + OW'(state_q == StWait)) < OW'(BUF_DEPTH);
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    drop_d   = drop_q;
    if (redirect_valid) begin
      pc_d = redirect_pc;
      if (req_fire || ((state_q == StWait) && !imem_resp_valid)) begin
        // Old request still in flight: wait for it and throw its response away.
        drop_d  = 1'b1;
        state_d = StWait;
      end else begin
        drop_d  = 1'b0;
        state_d = fault_next ? StIdle : StReq;
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          if (credit && !fault_q) state_d = StReq;
        end
        StReq: begin
          if (imem_req_ready) begin
            req_pc_d = pc_q;
            pc_d     = pc_q + XLEN'(4);
            state_d  = StWait;
          end
        end
        StWait: begin
          if (imem_resp_valid) begin
            drop_d  = 1'b0;
            state_d = (credit && !fault_q) ? StReq : StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  assign push_entry.pc   = req_pc_q;
  assign push_entry.inst = imem_resp_data;

  ifu_inst_buf #(
    .DEPTH (BUF_DEPTH),
    .WIDTH ($bits(buf_entry_t))
  ) u_inst_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (push_entry),
    .pop   (pop),
    .flush (redirect_valid),
    .rdata (head_entry),
    .count (buf_count),
    .empty (buf_empty)
  );

  assign imem_req_valid = (state_q == StReq);
  assign imem_req_addr  = imem_req_valid ? pc_q : '0;
  assign inst_valid     = !buf_empty && !redirect_valid;
  assign inst           = inst_valid ? head_entry.inst : '0;
  assign inst_pc        = inst_valid ? head_entry.pc : '0;
  assign fetch_fault    = fault_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch: vector table, directed corner cases, random vs stream model.
module tb_ifu_fetch;

  localparam logic [63:0] RST_PC = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid, imem_req_ready = 1'b0;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic        inst_valid, inst_ready = 1'b0;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        fetch_fault;

  always #5 clk = ~clk;

  ifu_fetch dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst            (inst),
    .inst_pc         (inst_pc),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .fetch_fault     (fetch_fault)
  );

  int errors = 0;
  int checks = 0;

  // Memory model: in-order responses after a per-request latency.
  typedef struct {
    logic [63:0] addr;
    int unsigned due;
  } pend_t;
  pend_t       pend_q[$];
  int unsigned cyc;
  int unsigned lat_min = 1, lat_max = 1;

  // Per-cycle stimulus and sampled outputs.
  logic        drv_ready, drv_iready, drv_redir;
  logic [63:0] drv_rpc;
  logic        s_req_valid, s_inst_valid, s_fault;
  logic [63:0] s_req_addr, s_inst_pc;
  logic [31:0] s_inst;

  // Reference model: the decode stream is sequential from the last redirect target.
  logic [63:0] exp_pc;
  int          deliveries, hs_count;
  logic        prev_hold;
  logic [63:0] prev_addr;

  typedef struct {
    logic        rdy;
    logic        irdy;
    logic        ev;
    logic [63:0] eaddr;
    logic        eiv;
    logic [63:0] epc;
    logic [31:0] einst;
  } vec_t;
  vec_t tbl[7];

  function automatic logic [31:0] word(input logic [63:0] a);
    return 32'h0010_0093 + {a[26:0], 5'b0};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    int unsigned lat;
    @(negedge clk);
    imem_req_ready  = drv_ready;
    inst_ready      = drv_iready;
    redirect_valid  = drv_redir;
    redirect_pc     = drv_rpc;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = word(pend_q[0].addr);
      pend_q.delete(0);
    end
    #1;
    s_req_valid  = imem_req_valid;
    s_req_addr   = imem_req_addr;
    s_inst_valid = inst_valid;
    s_inst_pc    = inst_pc;
    s_inst       = inst;
    s_fault      = fetch_fault;
    if (prev_hold) begin
      chk("req_held_valid", 64'(imem_req_valid), 64'd1);
      chk("req_held_addr", imem_req_addr, prev_addr);
    end
    if (imem_req_valid && imem_req_ready) begin
      chk("one_outstanding", 64'(pend_q.size()), 64'd0);
      lat = $urandom_range(lat_max, lat_min);
      pend_q.push_back('{imem_req_addr, cyc + lat});
      hs_count++;
    end
    prev_hold = imem_req_valid && !imem_req_ready && !redirect_valid;
    prev_addr = imem_req_addr;
    if (redirect_valid) begin
      chk("redirect_gates_valid", 64'(inst_valid), 64'd0);
      exp_pc = redirect_pc;
    end else if (inst_valid && inst_ready) begin
      chk("deliver_pc", inst_pc, exp_pc);
      chk("deliver_inst", 64'(inst), 64'(word(exp_pc)));
      exp_pc = exp_pc + 64'd4;
      deliveries++;
    end
    cyc++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n           = 1'b0;
    imem_req_ready  = 1'b0;
    inst_ready      = 1'b0;
    redirect_valid  = 1'b0;
    imem_resp_valid = 1'b0;
    pend_q.delete();
    drv_ready = 1'b0; drv_iready = 1'b0; drv_redir = 1'b0; drv_rpc = '0;
    #1;
    chk("rst_req_valid", 64'(imem_req_valid), 64'd0);
    chk("rst_req_addr", imem_req_addr, 64'd0);
    chk("rst_inst_valid", 64'(inst_valid), 64'd0);
    chk("rst_inst", 64'(inst), 64'd0);
    chk("rst_inst_pc", inst_pc, 64'd0);
    chk("rst_fault", 64'(fetch_fault), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_req_valid", 64'(imem_req_valid), 64'd0);
    cyc = 1; exp_pc = RST_PC; deliveries = 0; hs_count = 0; prev_hold = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Vectors after reset release: ready=1, 1-cycle latency, decode always ready.
    tbl[0] = '{1'b1, 1'b1, 1'b1, 64'h8000_0000, 1'b0, 64'h0, 32'h0};
    tbl[1] = '{1'b1, 1'b1, 1'b0, 64'h0,         1'b0, 64'h0, 32'h0};
    tbl[2] = '{1'b1, 1'b1, 1'b0, 64'h0,         1'b1, 64'h8000_0000, 32'h0010_0093};
    tbl[3] = '{1'b1, 1'b1, 1'b1, 64'h8000_0004, 1'b0, 64'h0, 32'h0};
    tbl[4] = '{1'b1, 1'b1, 1'b0, 64'h0,         1'b0, 64'h0, 32'h0};
    tbl[5] = '{1'b1, 1'b1, 1'b0, 64'h0,         1'b1, 64'h8000_0004, 32'h0010_0113};
    tbl[6] = '{1'b1, 1'b1, 1'b1, 64'h8000_0008, 1'b0, 64'h0, 32'h0};

    lat_min = 1; lat_max = 1;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      drv_ready = tbl[i].rdy; drv_iready = tbl[i].irdy; drv_redir = 1'b0;
      step();
      chk($sformatf("t1_req_valid c%0d", i + 1), 64'(s_req_valid), 64'(tbl[i].ev));
      if (tbl[i].ev) chk($sformatf("t1_req_addr c%0d", i + 1), s_req_addr, tbl[i].eaddr);
      chk($sformatf("t1_inst_valid c%0d", i + 1), 64'(s_inst_valid), 64'(tbl[i].eiv));
      if (tbl[i].eiv) begin
        chk($sformatf("t1_inst_pc c%0d", i + 1), s_inst_pc, tbl[i].epc);
        chk($sformatf("t1_inst c%0d", i + 1), 64'(s_inst), 64'(tbl[i].einst));
      end
    end

    // Decode stalled: buffer fills to two, then fetch stops.
    do_reset();
    drv_ready = 1'b1; drv_iready = 1'b0;
    repeat (10) step();
    chk("t2_hs_count", 64'(hs_count), 64'd2);
    chk("t2_req_idle", 64'(s_req_valid), 64'd0);
    chk("t2_head_valid", 64'(s_inst_valid), 64'd1);
    chk("t2_head_pc", s_inst_pc, RST_PC);
    drv_iready = 1'b1;
    repeat (2) step();
    chk("t2_drained", 64'(deliveries), 64'd2);

    // Memory not ready: request held stable, single handshake.
    do_reset();
    drv_ready = 1'b0; drv_iready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t3_req_valid", 64'(s_req_valid), 64'd1);
      chk("t3_req_addr", s_req_addr, RST_PC);
    end
    drv_ready = 1'b1;
    repeat (2) step();
    chk("t3_hs_count", 64'(hs_count), 64'd1);

    // Redirect while waiting: pending response discarded.
    lat_min = 3; lat_max = 3;
    do_reset();
    drv_ready = 1'b1; drv_iready = 1'b1;
    step();
    drv_redir = 1'b1; drv_rpc = 64'h8000_0100;
    step();
    drv_redir = 1'b0;
    repeat (3) step();
    chk("t4_req_valid", 64'(s_req_valid), 64'd1);
    chk("t4_req_addr", s_req_addr, 64'h8000_0100);
    repeat (4) step();
    chk("t4_delivered", 64'(deliveries), 64'd1);

    // Redirect coinciding with a response while one entry is buffered.
    lat_min = 1; lat_max = 1;
    do_reset();
    drv_ready = 1'b1; drv_iready = 1'b0;
    repeat (4) step();
    drv_redir = 1'b1; drv_rpc = 64'h8000_0200;
    step();
    chk("t5_redir_inst_valid", 64'(s_inst_valid), 64'd0);
    drv_redir = 1'b0;
    step();
    chk("t5_flushed", 64'(s_inst_valid), 64'd0);
    chk("t5_req_addr", s_req_addr, 64'h8000_0200);
    drv_iready = 1'b1;
    repeat (2) step();
    chk("t5_delivered", 64'(deliveries), 64'd1);

    // Misaligned redirect.
    do_reset();
    drv_ready = 1'b0; drv_iready = 1'b1;
    drv_redir = 1'b1; drv_rpc = 64'h8000_0102;
    step();
    drv_redir = 1'b0; drv_ready = 1'b1;
`ifdef IFU_ALIGN_CHECK_EN
    for (int i = 0; i < 10; i++) begin
      step();
      chk("t6_fault", 64'(s_fault), 64'd1);
      chk("t6_no_req", 64'(s_req_valid), 64'd0);
    end
`else
    step();
    chk("t6_req_addr", s_req_addr, 64'h8000_0102);
    repeat (2) step();
    chk("t6_delivered", 64'(deliveries), 64'd1);
    chk("t6_fault", 64'(s_fault), 64'd0);
`endif

    // Random traffic against the stream model, including PC wrap-around.
    lat_min = 1; lat_max = 3;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      drv_ready  = ($urandom_range(0, 3) != 0);
      drv_iready = ($urandom_range(0, 2) != 0);
      drv_redir  = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 3) == 0)
        drv_rpc = 64'hFFFF_FFFF_FFFF_FFE0 + 64'({$urandom_range(0, 7), 2'b00});
      else
        drv_rpc = RST_PC + 64'({$urandom_range(0, 255), 2'b00});
      step();
    end
    begin
      int target, n;
      drv_ready = 1'b1; drv_iready = 1'b1; drv_redir = 1'b0;
      target = deliveries + 6;
      n = 0;
      while (deliveries < target && n < 100) begin
        step();
        n++;
      end
      chk("rand_drain", 64'(deliveries >= target), 64'd1);
    end

    // Reset in the middle of traffic, then restart from RESET_PC.
    do_reset();
    drv_ready = 1'b1; drv_iready = 1'b1;
    repeat (20) step();
    chk("post_reset_progress", 64'(deliveries >= 3), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
